updown_count_display_driver: RTL and testbench

- Downstream consumer of the 8-bit up/down counter's count bus.
- Converts the 8-bit binary count to three BCD digits using a sequential shift-add-3 (double-dabble) engine, one iteration per clock.
- Time-multiplexes the digits onto a common-anode 3-digit 7-segment display.
- Sits between the counter and the board display pins; also exports the BCD digits and a valid pulse for other consumers.

---
 rtl/updown_count_display_driver.sv | 191 +++++++++++++++++++
 tb/tb_updown_count_display_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_count_display_driver.sv
// ============================================================================
// Module   : updown_count_display_driver
// Purpose  : 8-bit binary to 3-digit BCD (serial double-dabble) and 7-seg scan
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module updown_count_display_driver #(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count_in,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       bcd_valid,
  output logic       busy,
  output logic [2:0] an,
  output logic [6:0] seg
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        first_q, first_d;
  logic [7:0]  last_val_q, last_val_d;
  logic [19:0] shift_q, shift_d;
  logic [2:0]  iter_q, iter_d;
  logic [3:0]  bcd_hund_q, bcd_hund_d;
  logic [3:0]  bcd_tens_q, bcd_tens_d;
  logic [3:0]  bcd_ones_q, bcd_ones_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic        busy_q, busy_d;
  logic [15:0] scan_q, scan_d;
  logic [1:0]  digit_q, digit_d;
  logic [2:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [19:0] corr;
  logic [19:0] shifted;
  logic [3:0]  disp_digit;
  logic        disp_blank;

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    last_val_d  = last_val_q;
    shift_d     = shift_q;
    iter_d      = iter_q;
    bcd_hund_d  = bcd_hund_q;
    bcd_tens_d  = bcd_tens_q;
    bcd_ones_d  = bcd_ones_q;
    bcd_valid_d = 1'b0;
    busy_d      = busy_q;
    scan_d      = scan_q;
    digit_d     = digit_q;
    an_d        = an_q;
    seg_d       = seg_q;
    disp_digit  = bcd_ones_q;
    disp_blank  = 1'b0;

    // One double-dabble step: correct every BCD nibble, then shift the whole word.
    corr    = {add3(shift_q[19:16]), add3(shift_q[15:12]), add3(shift_q[11:8]), shift_q[7:0]};
    shifted = corr << 1;

    case (state_q)
      IDLE: begin
        if (first_q || (count_in != last_val_q)) begin
          shift_d    = {12'd0, count_in};
          last_val_d = count_in;
          first_d    = 1'b0;
          iter_d     = 3'd0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        shift_d = shifted;
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          bcd_hund_d  = shifted[19:16];
          bcd_tens_d  = shifted[15:12];
          bcd_ones_d  = shifted[11:8];
          bcd_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (scan_q == SCAN_LAST) begin
      scan_d  = 16'd0;
      digit_d = (digit_q == 2'd2) ? 2'd0 : (digit_q + 2'd1);
    end else begin
      scan_d = scan_q + 16'd1;
    end

    // Display reads the committed bcd registers, never the in-flight shift word.
    case (digit_q)
      2'd0: begin
        an_d       = 3'b110;
        disp_digit = bcd_ones_q;
        disp_blank = 1'b0;
      end
      2'd1: begin
        an_d       = 3'b101;
        disp_digit = bcd_tens_q;
        disp_blank = BLANK_LZ && (bcd_hund_q == 4'd0) && (bcd_tens_q == 4'd0);
      end
      default: begin
        an_d       = 3'b011;
        disp_digit = bcd_hund_q;
        disp_blank = BLANK_LZ && (bcd_hund_q == 4'd0);
      end
    endcase
    seg_d = disp_blank ? 7'b1111111 : seg_enc(disp_digit);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      first_q     <= 1'b1;
      last_val_q  <= 8'd0;
      shift_q     <= 20'd0;
      iter_q      <= 3'd0;
      bcd_hund_q  <= 4'd0;
      bcd_tens_q  <= 4'd0;
      bcd_ones_q  <= 4'd0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      scan_q      <= 16'd0;
      digit_q     <= 2'd0;
      an_q        <= 3'b111;
      seg_q       <= 7'b1111111;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      last_val_q  <= last_val_d;
      shift_q     <= shift_d;
      iter_q      <= iter_d;
      bcd_hund_q  <= bcd_hund_d;
      bcd_tens_q  <= bcd_tens_d;
      bcd_ones_q  <= bcd_ones_d;
      bcd_valid_q <= bcd_valid_d;
      busy_q      <= busy_d;
      scan_q      <= scan_d;
      digit_q     <= digit_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign bcd_hund  = bcd_hund_q;
  assign bcd_tens  = bcd_tens_q;
  assign bcd_ones  = bcd_ones_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = busy_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_updown_count_display_driver.sv
// ============================================================================
// Module   : tb_updown_count_display_driver
// Purpose  : directed self-checking bench for updown_count_display_driver
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_updown_count_display_driver;

  localparam logic [6:0] SEG_TAB [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk;
  logic       rst;
  logic [7:0] count_in;

  logic [3:0] bcd_hund, bcd_tens, bcd_ones;
  logic       bcd_valid, busy;
  logic [2:0] an;
  logic [6:0] seg;

  logic [3:0] nb_hund, nb_tens, nb_ones;
  logic       nb_valid, nb_busy;
  logic [2:0] nb_an;
  logic [6:0] nb_seg;

  int total  = 0;
  int passed = 0;

  updown_count_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .count_in(count_in),
    .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .bcd_valid(bcd_valid), .busy(busy), .an(an), .seg(seg)
  );

  updown_count_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .count_in(count_in),
    .bcd_hund(nb_hund), .bcd_tens(nb_tens), .bcd_ones(nb_ones),
    .bcd_valid(nb_valid), .busy(nb_busy), .an(nb_an), .seg(nb_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_digits(input string tag, input logic [7:0] v);
    chk({tag, "_hund"}, 32'(bcd_hund), 32'(v / 100));
    chk({tag, "_tens"}, 32'(bcd_tens), 32'((v / 10) % 10));
    chk({tag, "_ones"}, 32'(bcd_ones), 32'(v % 10));
  endtask

  // Drives a new value while idle and follows it through the 8-edge conversion.
  task automatic convert(input logic [7:0] v, input string tag);
    count_in = v;
    tick();
    chk({tag, "_busy_cap"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk({tag, "_busy_run"}, 32'({busy, bcd_valid}), 32'b10);
    end
    tick();
    chk({tag, "_done"}, 32'({busy, bcd_valid}), 32'b01);
    chk_digits(tag, v);
    tick();
    chk({tag, "_valid_drop"}, 32'(bcd_valid), 32'd0);
  endtask

  task automatic wait_an(input logic [2:0] a, input logic use_nb, input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (((use_nb ? nb_an : an) !== a) && (k < 20));
    chk({tag, "_an"}, 32'(use_nb ? nb_an : an), 32'(a));
  endtask

  logic [7:0] hist [0:127];
  logic [7:0] cnt;
  logic [7:0] prev_v;
  int         n_valid;

  initial begin
    rst      = 1'b0;
    count_in = 8'd0;
    tick();
    tick();
    chk("rst_busy", 32'({busy, bcd_valid}), 32'b00);
    chk("rst_bcd", 32'({bcd_hund, bcd_tens, bcd_ones}), 32'h000);
    chk("rst_an", 32'(an), 32'b111);
    chk("rst_seg", 32'(seg), 32'(BLANK));

    rst = 1'b1;
    convert(8'd0, "first");
    wait_an(3'b110, 1'b0, "z_ones");
    chk("z_ones_seg", 32'(seg), 32'(SEG_TAB[0]));
    wait_an(3'b101, 1'b0, "z_tens");
    chk("z_tens_seg", 32'(seg), 32'(BLANK));
    wait_an(3'b011, 1'b0, "z_hund");
    chk("z_hund_seg", 32'(seg), 32'(BLANK));

    convert(8'd255, "v255");
    chk("nb_v255", 32'({nb_hund, nb_tens, nb_ones}), 32'h255);
    wait_an(3'b011, 1'b1, "nb_hund");
    chk("nb_hund_seg", 32'(nb_seg), 32'(7'b0100100));
    wait_an(3'b101, 1'b1, "nb_tens");
    chk("nb_tens_seg", 32'(nb_seg), 32'(7'b0010010));
    wait_an(3'b110, 1'b1, "nb_ones");
    chk("nb_ones_seg", 32'(nb_seg), 32'(7'b0010010));

    convert(8'd100, "v100");
    wait_an(3'b101, 1'b0, "h_tens");
    chk("h_tens_seg", 32'(seg), 32'(SEG_TAB[0]));
    wait_an(3'b011, 1'b0, "h_hund");
    chk("h_hund_seg", 32'(seg), 32'(SEG_TAB[1]));

    convert(8'd7, "v7");
    wait_an(3'b011, 1'b0, "s_hund");
    chk("s_hund_seg", 32'(seg), 32'(BLANK));
    wait_an(3'b110, 1'b0, "s_ones");
    chk("s_ones_seg", 32'(seg), 32'(7'b1111000));
    wait_an(3'b101, 1'b0, "s_tens");
    chk("s_tens_seg", 32'(seg), 32'(BLANK));
    wait_an(3'b011, 1'b1, "s_nb_hund");
    chk("s_nb_hund_seg", 32'(nb_seg), 32'(SEG_TAB[0]));

    // Input change mid-conversion: old value finishes, new one captured at E+9.
    count_in = 8'd50;
    tick();
    chk("lat_cap", 32'(busy), 32'd1);
    tick(); tick(); tick();
    count_in = 8'd60;
    for (int i = 4; i <= 7; i++) tick();
    chk("lat_e7", 32'({busy, bcd_valid}), 32'b10);
    tick();
    chk("lat_e8", 32'({busy, bcd_valid}), 32'b01);
    chk_digits("lat_old", 8'd50);
    tick();
    chk("lat_e9", 32'({busy, bcd_valid}), 32'b10);
    for (int i = 10; i <= 16; i++) tick();
    tick();
    chk("lat_e17", 32'(bcd_valid), 32'd1);
    chk_digits("lat_new", 8'd60);
    tick();

    // Live up/down counter: each result must be the value seen 8 edges earlier.
    cnt      = 8'd3;
    count_in = cnt;
    hist[1]  = cnt;
    prev_v   = 8'd60;
    n_valid  = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (bcd_valid) begin
        n_valid++;
        if (n > 8) prev_v = hist[n - 8];
        chk_digits("live", prev_v);
      end else begin
        chk("live_hold", 32'({bcd_hund, bcd_tens, bcd_ones}),
            32'({4'(prev_v / 100), 4'((prev_v / 10) % 10), 4'(prev_v % 10)}));
      end
      cnt         = (n <= 20) ? (cnt + 8'd1) : (cnt - 8'd1);
      count_in    = cnt;
      hist[n + 1] = cnt;
    end
    chk("live_npulse", 32'(n_valid), 32'd6);
    for (int i = 0; i < 20; i++) tick();

    convert(8'd0, "wrap0");
    convert(8'd255, "wrap255");

    // Reset at iteration 4, then forced reconversion and scan timing from reset.
    count_in = 8'd123;
    tick();
    for (int i = 1; i <= 4; i++) tick();
    rst = 1'b0;
    tick();
    chk("mid_busy", 32'({busy, bcd_valid}), 32'b00);
    chk("mid_bcd", 32'({bcd_hund, bcd_tens, bcd_ones}), 32'h000);
    chk("mid_an", 32'(an), 32'b111);
    chk("mid_seg", 32'(seg), 32'(BLANK));
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      case (((k - 1) / 4) % 3)
        0:       chk("scan_an", 32'(an), 32'b110);
        1:       chk("scan_an", 32'(an), 32'b101);
        default: chk("scan_an", 32'(an), 32'b011);
      endcase
      if (k <= 8) begin
        chk("re_busy", 32'({busy, bcd_valid}), 32'b10);
      end else if (k == 9) begin
        chk("re_done", 32'({busy, bcd_valid}), 32'b01);
        chk_digits("re", 8'd123);
      end else begin
        chk("re_idle", 32'({busy, bcd_valid}), 32'b00);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
